// File: rtl/sprite_sched_pkg.sv
// Shared types and helpers for the sprite scheduler: state encoding, default
// pixel widths, colour constants, request decoding and packed-bus selection.
package sprite_sched_pkg;

    localparam int DEF_X_W = 9;
    localparam int DEF_Y_W = 8;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] ALIEN = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ERASE_REQ  = 3'd1,
        S_ERASE_WAIT = 3'd2,
        S_DRAW_REQ   = 3'd3,
        S_DRAW_WAIT  = 3'd4,
        S_NEXT       = 3'd5,
        S_DONE       = 3'd6
    } sched_state_t;

    // One bit of a one-hot request vector; en gates the whole vector to zero.
    function automatic logic req_bit(input int idx, input int bit_pos, input logic en);
        return en && (idx == bit_pos);
    endfunction

    // Field idx (w bits each) of a packed per-sprite bus, LSB field = sprite 0.
    function automatic logic [31:0] bus_field(input logic [255:0] bus, input int unsigned idx,
                                              input int unsigned w);
        logic [255:0] mask;
        mask = (256'(1) << w) - 256'(1);
        return 32'((bus >> (idx * w)) & mask);
    endfunction

endpackage

// File: rtl/sprite_scheduler.sv
// Round-robin erase/redraw sequencer for the sprite engines, sharing one VGA
// write port; each engine is erased, redrawn and awaited before the next.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for frame_tick; en_q latched and idx cleared on it
// ERASE_REQ  | one-cycle erase_signal[idx], wait counter cleared
// ERASE_WAIT | streaming engine pixels until finish[idx] or timeout
// DRAW_REQ   | one-cycle draw_signal[idx], wait counter cleared
// DRAW_WAIT  | streaming engine pixels until finish[idx] or timeout
// NEXT       | advance idx; a disabled sprite costs one cycle here
// DONE       | one-cycle round_done, back to IDLE
module sprite_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int N_SPRITES = 3,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic [N_SPRITES-1:0]     sprite_en,
    input  logic [N_SPRITES*X_W-1:0] sprite_x,
    input  logic [N_SPRITES*Y_W-1:0] sprite_y,
    input  logic [N_SPRITES*3-1:0]   sprite_colour,
    input  logic [N_SPRITES-1:0]     sprite_finish,
    output logic [N_SPRITES-1:0]     draw_signal,
    output logic [N_SPRITES-1:0]     erase_signal,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [2:0]               vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic                     round_done,
    output logic                     timeout_err,
    output logic                     overrun
);

    localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPRITES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    sched_state_t         state, state_d;
    logic [IDX_W-1:0]     idx, idx_d, idx_inc;
    logic [N_SPRITES-1:0] en_q, en_d;
    logic [CNT_W-1:0]     cnt, cnt_d, cnt_inc;
    logic                 tmo_set, plot_d, in_wait, finish_sel;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [2:0]           sel_colour;

    assign idx_inc    = idx + 1'b1;
    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign finish_sel = sprite_finish[idx];
    assign in_wait    = (state == S_ERASE_WAIT) || (state == S_DRAW_WAIT);
    assign busy       = (state != S_IDLE);
    assign round_done = (state == S_DONE);

    assign sel_x      = X_W'(bus_field(256'(sprite_x), 32'(idx), X_W));
    assign sel_y      = Y_W'(bus_field(256'(sprite_y), 32'(idx), Y_W));
    assign sel_colour = 3'(bus_field(256'(sprite_colour), 32'(idx), 3));

    always_comb begin
        erase_signal = '0;
        draw_signal  = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            erase_signal[i] = req_bit(32'(idx), i, state == S_ERASE_REQ);
            draw_signal[i]  = req_bit(32'(idx), i, state == S_DRAW_REQ);
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        en_d    = en_q;
        cnt_d   = cnt;
        tmo_set = 1'b0;
        plot_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_tick) begin
                    en_d    = sprite_en;
                    idx_d   = '0;
                    state_d = sprite_en[0] ? S_ERASE_REQ : S_NEXT;
                end
            end
            S_ERASE_REQ: begin
                cnt_d   = '0;
                state_d = S_ERASE_WAIT;
            end
            S_DRAW_REQ: begin
                cnt_d   = '0;
                state_d = S_DRAW_WAIT;
            end
            S_ERASE_WAIT, S_DRAW_WAIT: begin
                // finish wins over a coincident timeout; plot only while staying in WAIT
                if (finish_sel) begin
                    state_d = (state == S_ERASE_WAIT) ? S_DRAW_REQ : S_NEXT;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        tmo_set = 1'b1;
                        state_d = (state == S_ERASE_WAIT) ? S_DRAW_REQ : S_NEXT;
                    end else begin
                        plot_d = 1'b1;
                    end
                end
            end
            S_NEXT: begin
                if (idx == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_inc;
                    state_d = en_q[idx_inc] ? S_ERASE_REQ : S_NEXT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            en_q        <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= BLACK;
            vga_plot    <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            en_q     <= en_d;
            cnt      <= cnt_d;
            vga_plot <= plot_d;
            if (tmo_set) timeout_err <= 1'b1;
            if (frame_tick && (state != S_IDLE)) overrun <= 1'b1;
            if (in_wait) begin
                vga_x      <= sel_x;
                vga_y      <= sel_y;
                vga_colour <= sel_colour;
            end
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: round ordering, skipped sprites, timeout,
// overrun, VGA mux latency and mid-round reset.
module tb_sprite_scheduler;
    import sprite_sched_pkg::*;

    localparam int N  = 3;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int TO = 255;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            frame_tick = 1'b0;
    logic [N-1:0]    sprite_en = '0;
    logic [N*XW-1:0] sprite_x = '0;
    logic [N*YW-1:0] sprite_y = '0;
    logic [N*3-1:0]  sprite_colour = '0;
    logic [N-1:0]    sprite_finish = '0;
    logic [N-1:0]    draw_signal, erase_signal;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [2:0]      vga_colour;
    logic            vga_plot, busy, round_done, timeout_err, overrun;

    int checks = 0;
    int failures = 0;

    sprite_scheduler #(.N_SPRITES(N), .X_W(XW), .Y_W(YW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .sprite_en(sprite_en),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_colour(sprite_colour),
        .sprite_finish(sprite_finish), .draw_signal(draw_signal),
        .erase_signal(erase_signal), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
        .round_done(round_done), .timeout_err(timeout_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (erase_signal == '0 && draw_signal == '0 && n < 600) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!round_done && n < 600) begin
            step();
            n++;
        end
    endtask

    // Expect one request after exp_gap cycles, then return finish delay cycles later.
    task automatic serve(input bit is_draw, input int idx, input int delay, input int exp_gap,
                         input string tag);
        int n;
        int bad;
        wait_req(n);
        chk({tag, "_gap"}, 32'(n), 32'(exp_gap));
        chk({tag, "_req"}, 32'(is_draw ? draw_signal : erase_signal), 32'(1 << idx));
        chk({tag, "_other"}, 32'(is_draw ? erase_signal : draw_signal), 32'(0));
        bad = 0;
        for (int k = 0; k < delay; k++) begin
            step();
            if (erase_signal != '0 || draw_signal != '0 || round_done || !busy) bad++;
        end
        chk({tag, "_quiet"}, 32'(bad), 32'(0));
        sprite_finish = N'(1 << idx);
        step();
        sprite_finish = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;

        #2 reset = 1'b0;
        step();
        step();
        chk("rst_flags", 32'({busy, round_done, timeout_err, overrun, vga_plot}), 32'(0));
        chk("rst_req", 32'({erase_signal, draw_signal}), 32'(0));
        chk("rst_vga", 32'({vga_x, vga_y, vga_colour}), 32'(0));
        @(negedge clk) reset = 1'b1;
        step();

        // full round, 40-cycle engine latency; sprite_en changed after latch
        sprite_en = 3'b111;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        sprite_en = 3'b000;
        chk("t1_busy", 32'(busy), 32'(1));
        serve(0, 0, 40, 0, "t1_0e");
        serve(1, 0, 40, 0, "t1_0d");
        serve(0, 1, 40, 1, "t1_1e");
        serve(1, 1, 40, 0, "t1_1d");
        serve(0, 2, 40, 1, "t1_2e");
        serve(1, 2, 40, 0, "t1_2d");
        wait_done(n);
        chk("t1_done_gap", 32'(n), 32'(1));
        chk("t1_done_busy", 32'(busy), 32'(1));
        step();
        chk("t1_idle", 32'({busy, round_done}), 32'(0));
        chk("t1_no_overrun", 32'(overrun), 32'(0));

        // only sprite 1 enabled
        sprite_en = 3'b010;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        serve(0, 1, 5, 1, "t2_1e");
        serve(1, 1, 5, 0, "t2_1d");
        wait_done(n);
        chk("t2_done_gap", 32'(n), 32'(2));
        step();
        chk("t2_idle", 32'(busy), 32'(0));

        // sprite 0 never finishes its erase
        sprite_en = 3'b001;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("t3_erase", 32'(erase_signal), 32'(1));
        for (int k = 0; k < TO - 1; k++) step();
        step();
        chk("t3_pre_tmo", 32'({timeout_err, draw_signal}), 32'(0));
        chk("t3_pre_plot", 32'(vga_plot), 32'(1));
        step();
        chk("t3_tmo", 32'(timeout_err), 32'(1));
        chk("t3_draw", 32'(draw_signal), 32'(1));
        chk("t3_tmo_plot", 32'(vga_plot), 32'(0));
        serve(1, 0, 3, 0, "t3_0d");
        wait_done(n);
        chk("t3_done_gap", 32'(n), 32'(3));
        step();
        chk("t3_sticky", 32'(timeout_err), 32'(1));

        // frame_tick during DRAW_WAIT
        chk("t4_pre_overrun", 32'(overrun), 32'(0));
        sprite_en = 3'b001;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        serve(0, 0, 3, 0, "t4_0e");
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("t4_overrun", 32'(overrun), 32'(1));
        chk("t4_no_restart", 32'({erase_signal, draw_signal}), 32'(0));
        sprite_finish = 3'b001;
        step();
        sprite_finish = '0;
        wait_done(n);
        chk("t4_done_gap", 32'(n), 32'(3));
        step();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (busy || round_done || erase_signal != '0 || draw_signal != '0) bad++;
            step();
        end
        chk("t4_stays_idle", 32'(bad), 32'(0));

        // VGA mux on sprite 1
        sprite_x = {9'd7, 9'd100, 9'd3};
        sprite_y = {8'd30, 8'd20, 8'd10};
        sprite_colour = {3'b001, ALIEN, 3'b010};
        sprite_en = 3'b010;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        serve(0, 1, 2, 1, "t5_1e");
        chk("t5_draw", 32'(draw_signal), 32'(3'b010));
        chk("t5_req_plot", 32'(vga_plot), 32'(0));
        step();
        chk("t5_w1_plot", 32'(vga_plot), 32'(0));
        step();
        chk("t5_plot", 32'(vga_plot), 32'(1));
        chk("t5_x", 32'(vga_x), 32'(100));
        chk("t5_y", 32'(vga_y), 32'(20));
        chk("t5_colour", 32'(vga_colour), 32'(ALIEN));
        sprite_finish = 3'b101;
        step();
        chk("t5_foreign_finish", 32'({vga_plot, busy, round_done}), 32'(3'b110));
        sprite_finish = 3'b010;
        step();
        sprite_finish = '0;
        chk("t5_plot_after_fin", 32'(vga_plot), 32'(0));
        sprite_x = {9'd7, 9'd55, 9'd3};
        step();
        chk("t5_x_hold", 32'(vga_x), 32'(100));
        wait_done(n);
        chk("t5_done_gap", 32'(n), 32'(1));
        step();

        // reset in the middle of ERASE_WAIT
        sprite_en = 3'b111;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        chk("t6_flags", 32'({busy, round_done, timeout_err, overrun, vga_plot}), 32'(0));
        chk("t6_req", 32'({erase_signal, draw_signal}), 32'(0));
        chk("t6_vga", 32'({vga_x, vga_y, vga_colour}), 32'(0));
        @(negedge clk) reset = 1'b1;
        step();
        step();
        chk("t6_abandoned", 32'({busy, erase_signal, draw_signal}), 32'(0));
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("t6_restart", 32'(erase_signal), 32'(3'b001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
